// File: rtl/router_pkt_pkg.sv
// Shared header constants and helpers for the router packet
// flit encoder and decoder.
package router_pkt_pkg;

  localparam int HDR_TTL_W    = 2;
  localparam int HDR_SEQ_W    = 5;
  localparam int HDR_SRC_W    = 2;
  localparam int HDR_TTL_INIT = 3;
  localparam int HDR_SRC_ID   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pkt_flit_encoder_if.sv
// Packet-in / flit-out handshake bundle for the flit encoder.
// Master drives packets and flit backpressure; slave is the encoder.
interface pkt_flit_encoder_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int FLIT_WIDTH = 64
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_dst_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_last;
  logic                  encode_done;

  modport master (
    output in_valid,
    output in_data,
    output in_dst_addr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_flit,
    input  out_last,
    input  encode_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dst_addr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_flit,
    output out_last,
    output encode_done
  );

endinterface

// File: rtl/flit_hdr_pack.sv
// Slices one payload chunk out of the packet shadow and prepends it
// to the TTL / sequence / source header.
module flit_hdr_pack #(
  parameter int SHADOW_W  = 1034,
  parameter int PAYLOAD_W = 55,
  parameter int NUM_FLITS = 19,
  parameter int TTL_W     = 2,
  parameter int SEQ_W     = 5,
  parameter int SRC_W     = 2,
  parameter int TTL_INIT  = 3,
  parameter int SRC_ID    = 0,
  localparam int FW = PAYLOAD_W + TTL_W + SEQ_W + SRC_W
) (
  input  logic [SHADOW_W-1:0] shadow_i,
  input  logic [SEQ_W-1:0]    idx_i,
  output logic [FW-1:0]       flit_o
);

  localparam int EXT_W = NUM_FLITS * PAYLOAD_W;

  logic [EXT_W-1:0]     ext;
  logic [PAYLOAD_W-1:0] slice;

  // Zero-extension supplies the pad bits of the final flit.
  assign ext    = EXT_W'(shadow_i);
  assign slice  = ext[idx_i*PAYLOAD_W +: PAYLOAD_W];
  assign flit_o = {slice, TTL_W'(TTL_INIT), idx_i, SRC_W'(SRC_ID)};

endmodule

// File: rtl/pkt_flit_encoder.sv
// Splits one wide packet (data + destination) into a stream of
// header-tagged flits with valid/ready backpressure.
module pkt_flit_encoder
  import router_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int FLIT_WIDTH = 64,
  parameter int TTL_W      = HDR_TTL_W,
  parameter int SEQ_W      = HDR_SEQ_W,
  parameter int SRC_W      = HDR_SRC_W,
  parameter int TTL_INIT   = HDR_TTL_INIT,
  parameter int SRC_ID     = HDR_SRC_ID
) (
  input logic              clk,
  input logic              rst_n,
  pkt_flit_encoder_if.slave bus
);

  localparam int PAYLOAD_W = FLIT_WIDTH - TTL_W - SEQ_W - SRC_W;
  localparam int SHADOW_W  = DATA_WIDTH + ADDR_WIDTH;
  localparam int PW_SAFE   = (PAYLOAD_W < 1) ? 1 : PAYLOAD_W;
  localparam int NUM_FLITS = ceil_div(SHADOW_W, PW_SAFE);
  localparam logic [SEQ_W-1:0] LAST = SEQ_W'(NUM_FLITS - 1);

  if ((NUM_FLITS - 1) > ((1 << SEQ_W) - 1) || PAYLOAD_W < 1) begin : g_bad_cfg
    $error("pkt_flit_encoder: flit count or payload width invalid");
  end

  enc_state_e            state_q, state_d;
  logic [SEQ_W-1:0]      cnt_q, cnt_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic [FLIT_WIDTH-1:0] flit_nxt;

  flit_hdr_pack #(
    .SHADOW_W  (SHADOW_W),
    .PAYLOAD_W (PW_SAFE),
    .NUM_FLITS (NUM_FLITS),
    .TTL_W     (TTL_W),
    .SEQ_W     (SEQ_W),
    .SRC_W     (SRC_W),
    .TTL_INIT  (TTL_INIT),
    .SRC_ID    (SRC_ID)
  ) u_pack (
    .shadow_i (shadow_d),
    .idx_i    (cnt_d),
    .flit_o   (flit_nxt)
  );

  // Outputs are built from next-state so flit 0 lands one cycle
  // after capture and a stalled flit simply re-registers itself.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          shadow_d    = {bus.in_data, bus.in_dst_addr};
          cnt_d       = '0;
          state_d     = ST_SEND;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          in_ready_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (cnt_q == LAST) begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            cnt_d = cnt_q + SEQ_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_flit_d = out_valid_d ? flit_nxt : '0;
    out_last_d = out_valid_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_flit    = out_flit_q;
  assign bus.out_last    = out_last_q;
  assign bus.encode_done = done_q;

endmodule

// File: tb/tb_pkt_flit_encoder.sv
// Self-checking bench for pkt_flit_encoder: hand vectors, backpressure,
// held-valid, mid-packet reset, random packets, and a narrow config.
module tb_pkt_flit_encoder;

  localparam int DW = 1024;
  localparam int AW = 10;
  localparam int FW = 64;
  localparam int P  = 55;
  localparam int NF = 19;

  localparam int SDW = 256;
  localparam int SFW = 32;
  localparam int SP  = 23;
  localparam int SNF = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_flit_encoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIT_WIDTH(FW)) bus ();
  pkt_flit_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIT_WIDTH(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pkt_flit_encoder_if #(.DATA_WIDTH(SDW), .ADDR_WIDTH(AW), .FLIT_WIDTH(SFW)) bus_s ();
  pkt_flit_encoder #(.DATA_WIDTH(SDW), .ADDR_WIDTH(AW), .FLIT_WIDTH(SFW)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [63:0]   f0;
    logic [63:0]   flast;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [DW-1:0] d,
                                        input logic [AW-1:0] a,
                                        input int k);
    logic [NF*P-1:0] ext;
    logic [NF*P-1:0] sh;
    logic [4:0]      s;
    ext = {{(NF*P-DW-AW){1'b0}}, d, a};
    sh  = ext >> (k * P);
    s   = k[4:0];
    return {sh[P-1:0], 2'd3, s, 2'd0};
  endfunction

  function automatic logic [31:0] model_s(input logic [SDW-1:0] d,
                                          input logic [AW-1:0] a,
                                          input int k);
    logic [SNF*SP-1:0] ext;
    logic [SNF*SP-1:0] sh;
    logic [4:0]        s;
    ext = {{(SNF*SP-SDW-AW){1'b0}}, d, a};
    sh  = ext >> (k * SP);
    s   = k[4:0];
    return {sh[SP-1:0], 2'd3, s, 2'd0};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic start_pkt(input logic [DW-1:0] d, input logic [AW-1:0] a,
                           input bit hold);
    int t;
    t = 0;
    bus.in_data     = d;
    bus.in_dst_addr = a;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: alternating starting low, else random
  task automatic collect(input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input int mode, output int cyc,
                         output logic [63:0] f0, output logic [63:0] fl);
    int k;
    bit rdy;
    k = 0; cyc = 0; f0 = '0; fl = '0;
    while (k < NF && cyc < 400) begin
      chk("out_valid", bus.out_valid, 1);
      chk("flit", bus.out_flit, model(d, a, k));
      chk("out_last", bus.out_last, (k == NF - 1));
      chk("in_ready_send", bus.in_ready, 0);
      if (k == 0) f0 = bus.out_flit;
      if (k == NF - 1) fl = bus.out_flit;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    chk("flits_done", k, NF);
    chk("done_pulse", bus.encode_done, 1);
    chk("valid_after", bus.out_valid, 0);
    chk("flit_idle", bus.out_flit, 0);
    chk("last_after", bus.out_last, 0);
    chk("ready_after", bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [63:0] f0, fl;
    logic [DW-1:0] da, db;
    logic [AW-1:0] aa, ab;
    logic [SDW-1:0] ds;
    logic [AW-1:0]  as;

    bus.in_valid = 0; bus.in_data = '0; bus.in_dst_addr = '0;
    bus.out_ready = 0;
    bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.in_dst_addr = '0;
    bus_s.out_ready = 0;

    tbl[0].d = '0; tbl[0].d[0] = 1'b1; tbl[0].a = 10'h2A;
    tbl[0].f0 = 64'h0000_0000_0008_5580;
    tbl[0].flast = 64'h0000_0000_0000_01C8;
    tbl[1].d = '1; tbl[1].a = '1;
    tbl[1].f0 = 64'hFFFF_FFFF_FFFF_FF80;
    tbl[1].flast = 64'h001F_FFFF_FFFF_FFC8;
    tbl[2].d = '0; tbl[2].a = '0;
    tbl[2].f0 = 64'h0000_0000_0000_0180;
    tbl[2].flast = 64'h0000_0000_0000_01C8;
    tbl[3].d = '0; tbl[3].d[DW-1] = 1'b1; tbl[3].a = 10'h155;
    tbl[3].f0 = 64'h0000_0000_0002_AB80;
    tbl[3].flast = 64'h0010_0000_0000_01C8;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flit", bus.out_flit, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_done", bus.encode_done, 0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      start_pkt(tbl[i].d, tbl[i].a, 1'b0);
      collect(tbl[i].d, tbl[i].a, 0, cyc, f0, fl);
      chk("tbl_flit0", f0, tbl[i].f0);
      chk("tbl_flit_last", fl, tbl[i].flast);
      chk("stream_cycles", cyc, NF);
      @(negedge clk);
      chk("done_one_cycle", bus.encode_done, 0);
    end

    da = rand_data(); aa = AW'($urandom());
    start_pkt(da, aa, 1'b0);
    collect(da, aa, 1, cyc, f0, fl);
    chk("toggle_cycles", cyc, 2 * NF);

    da = rand_data(); aa = AW'($urandom());
    db = rand_data(); ab = AW'($urandom());
    start_pkt(da, aa, 1'b1);
    bus.in_data = db;
    bus.in_dst_addr = ab;
    collect(da, aa, 0, cyc, f0, fl);
    @(negedge clk);
    bus.in_valid = 1'b0;
    collect(db, ab, 0, cyc, f0, fl);
    @(negedge clk);

    da = rand_data(); aa = AW'($urandom());
    start_pkt(da, aa, 1'b0);
    bus.out_ready = 1'b1;
    repeat (7) @(negedge clk);
    chk("pre_rst_flit7", bus.out_flit, model(da, aa, 7));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_flit", bus.out_flit, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", bus.in_ready, 1);
    db = rand_data(); ab = AW'($urandom());
    start_pkt(db, ab, 1'b0);
    collect(db, ab, 0, cyc, f0, fl);

    for (int n = 0; n < 20; n++) begin
      da = rand_data(); aa = AW'($urandom());
      start_pkt(da, aa, 1'b0);
      collect(da, aa, 2, cyc, f0, fl);
    end

    for (int w = 0; w < SDW / 32; w++) ds[w*32 +: 32] = $urandom();
    as = AW'($urandom());
    @(negedge clk);
    chk("s_in_ready", bus_s.in_ready, 1);
    bus_s.in_data = ds;
    bus_s.in_dst_addr = as;
    bus_s.in_valid = 1'b1;
    bus_s.out_ready = 1'b1;
    @(negedge clk);
    bus_s.in_valid = 1'b0;
    for (int k = 0; k < SNF; k++) begin
      chk("s_valid", bus_s.out_valid, 1);
      chk("s_flit", bus_s.out_flit, model_s(ds, as, k));
      chk("s_last", bus_s.out_last, (k == SNF - 1));
      @(negedge clk);
    end
    chk("s_done", bus_s.encode_done, 1);
    chk("s_valid_after", bus_s.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
